// File: rtl/kernel_distribution_sequencer_if.sv
// Handshake/config bundle between the layer controller, kernel buffer,
// distributor and PE array. The sequencer connects through the master modport.
interface kernel_distribution_sequencer_if #(
  parameter int depth = 2,
  parameter int AW    = 10
);
  logic             start;
  logic [depth-1:0] cfgTrc;
  logic [AW-1:0]    cfgWords;
  logic             busy;
  logic             done;
  logic             bufRdEn;
  logic [AW-1:0]    bufRdAddr;
  logic [depth-1:0] bankSelect;
  logic [depth-1:0] Trc;
  logic             opValid;
  logic             opReady;

  modport master (
    input  start, cfgTrc, cfgWords, opReady,
    output busy, done, bufRdEn, bufRdAddr, bankSelect, Trc, opValid
  );

  modport slave (
    output start, cfgTrc, cfgWords, opReady,
    input  busy, done, bufRdEn, bufRdAddr, bankSelect, Trc, opValid
  );
endinterface

// File: rtl/kernel_distribution_sequencer.sv
// Walks kernel buffer addresses (outer) and distributor banks (inner) for one
// pass, issuing one buffer read per beat under valid/ready back-pressure.
module kernel_distribution_sequencer #(
  parameter int depth = 2,
  parameter int D     = 1 << depth,
  parameter int AW    = 10
) (
  input  logic clk,
  input  logic reset,
  kernel_distribution_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [depth-1:0] BANK_MAX = depth'(D - 1);

  state_e           state_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    words_q;
  logic [depth-1:0] bank_q;
  logic [depth-1:0] trc_q;
  logic [depth-1:0] bank_sel_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic             issue_s;
  logic             bank_wrap_s;
  logic             last_addr_s;

  // A read issues whenever the output slot is free or being drained this cycle.
  always_comb begin
    issue_s     = 1'b0;
    bank_wrap_s = (bank_q == trc_q) || (bank_q == BANK_MAX);
    last_addr_s = (addr_q == (words_q - AW'(1)));
    if ((state_q == RUN) && (!valid_q || bus.opReady)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bufRdEn    = issue_s;
  assign bus.bufRdAddr  = addr_q;
  assign bus.bankSelect = bank_sel_q;
  assign bus.Trc        = trc_q;
  assign bus.opValid    = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      words_q    <= '0;
      bank_q     <= '0;
      trc_q      <= '0;
      bank_sel_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // busy stays high through the done cycle and drops one cycle later.
      if (done_q) begin
        busy_q <= 1'b0;
      end

      if (issue_s) begin
        valid_q <= 1'b1;
      end else if (bus.opReady) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.start && !busy_q) begin
            trc_q   <= bus.cfgTrc;
            words_q <= bus.cfgWords;
            addr_q  <= '0;
            bank_q  <= '0;
            busy_q  <= 1'b1;
            // An empty pass has nothing to drain, so done fires at once.
            if (bus.cfgWords == '0) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (issue_s) begin
            bank_sel_q <= bank_q;
            if (bank_wrap_s) begin
              bank_q <= '0;
              if (last_addr_s) begin
                state_q <= DRAIN;
              end else begin
                addr_q <= addr_q + AW'(1);
              end
            end else begin
              bank_q <= bank_q + depth'(1);
            end
          end
        end
        DRAIN: begin
          if (!valid_q || bus.opReady) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
